// File: rtl/sar_dac_sequencer.sv
// sar_dac_sequencer
//   Successive-approximation sequencer. Holds the sample strobe for T_SAMP
//   cycles, then binary-searches the DAC code one bit at a time (MSB first),
//   giving the DAC SETTLE cycles per trial before the comparator is used.
//
// Ports
//   clk       : system clock, all logic on the rising edge
//   rst       : synchronous active-high reset
//   start     : conversion request, only looked at in IDLE
//   abort     : cancel a conversion in progress (wins over start in IDLE)
//   vref_sel  : reference select, latched when start is accepted
//   comp      : comparator, 1 = DAC output above input
//   dac_code  : trial code driven to the DAC
//   vref_out  : latched reference select driven to the DAC
//   sample    : track/hold strobe, high during SAMPLE
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse in the cycle result is updated
//   result    : last completed conversion
//   state_dbg : current FSM state (IDLE=0, SAMPLE=1, SETTLE=2, DECIDE=3, DONE=4)
//
// Handshake: start is a level request; it is accepted on the first rising
// edge that sees start=1, abort=0 while the block is in IDLE. Requests made
// while busy are dropped, not queued.
module sar_dac_sequencer #(
    parameter int N      = 8,
    parameter int T_SAMP = 2,
    parameter int SETTLE = 3,
    parameter int VREF_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [VREF_W-1:0] vref_sel,
    input  logic              comp,
    output logic [N-1:0]      dac_code,
    output logic [VREF_W-1:0] vref_out,
    output logic              sample,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      result,
    output logic [2:0]        state_dbg
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_DECIDE = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam int CNT_MAX = (T_SAMP > SETTLE) ? T_SAMP : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(N);

    localparam logic [CNT_W-1:0] SAMP_LOAD   = CNT_W'(T_SAMP - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0] IDX_TOP     = IDX_W'(N - 1);

    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     decide_code;

    assign state_dbg = state;

    // Code after the current decision: drop the trial bit if the DAC was
    // above the input, and raise the next lower bit as the new trial.
    always_comb begin
        decide_code = dac_code;
        if (comp) begin
            decide_code[idx] = 1'b0;
        end
        if (idx != '0) begin
            decide_code[idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            idx      <= '0;
            dac_code <= '0;
            vref_out <= '0;
            result   <= '0;
            sample   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            // DONE is excluded: its result is already committed, so it
            // finishes normally even if abort arrives in that cycle.
            if (abort && (state == S_SAMPLE || state == S_SETTLE || state == S_DECIDE)) begin
                state    <= S_IDLE;
                sample   <= 1'b0;
                busy     <= 1'b0;
                dac_code <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state    <= S_SAMPLE;
                            vref_out <= vref_sel;
                            dac_code <= '0;
                            idx      <= IDX_TOP;
                            cnt      <= SAMP_LOAD;
                            sample   <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        if (cnt == '0) begin
                            state    <= S_SETTLE;
                            sample   <= 1'b0;
                            dac_code <= {1'b1, {(N-1){1'b0}}};
                            cnt      <= SETTLE_LOAD;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt == '0) begin
                            state <= S_DECIDE;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    S_DECIDE: begin
                        dac_code <= decide_code;
                        if (idx == '0) begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            result <= decide_code;
                        end else begin
                            state <= S_SETTLE;
                            idx   <= idx - 1'b1;
                            cnt   <= SETTLE_LOAD;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state  <= S_IDLE;
                        sample <= 1'b0;
                        busy   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sar_dac_sequencer.sv
// Testbench for sar_dac_sequencer: ideal comparator against an input level
// vin, binary-search reference model, latency/strobe/abort/reset checks.
module tb_sar_dac_sequencer;
    localparam int N       = 8;
    localparam int LAT     = 2 + N * (3 + 1);   // accept edge to done edge
    localparam int GAP     = LAT + 2;           // accept-to-accept with start held
    localparam int IDLE_ST = 0;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         abort;
    logic [3:0]   vref_sel;
    logic         comp;
    logic [N-1:0] vin;
    logic [N-1:0] dac_code;
    logic [3:0]   vref_out;
    logic         sample;
    logic         busy;
    logic         done;
    logic [N-1:0] result;
    logic [2:0]   state_dbg;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    logic [N-1:0] exp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ideal comparator
    assign comp = (dac_code > vin);

    sar_dac_sequencer #(.N(N), .T_SAMP(2), .SETTLE(3), .VREF_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .vref_sel(vref_sel), .comp(comp), .dac_code(dac_code),
        .vref_out(vref_out), .sample(sample), .busy(busy), .done(done),
        .result(result), .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Binary search from first principles: try each bit MSB first, keep it
    // if the trial does not exceed the input. Queues every trial code.
    function automatic logic [N-1:0] sar_model(input logic [N-1:0] v);
        logic [N-1:0] code;
        logic [N-1:0] trial;
        code = '0;
        for (int i = N - 1; i >= 0; i--) begin
            trial = code | (N'(1) << i);
            exp_q.push_back(trial);
            if (trial <= v) code = trial;
        end
        return code;
    endfunction

    // ---------------- driver ----------------
    // One conversion. k counts edges after the accept edge (k=0). Trial j
    // (MSB first) appears after edge 2+4j; done after edge LAT; IDLE at LAT+1.
    task automatic convert(input logic [N-1:0] v, input logic [3:0] vs, input int abort_k,
                           input bit hold, input bit poke, input logic [N-1:0] prev_res,
                           output int acc_cyc);
        logic [N-1:0] exp_res;
        int samp_n, busy_n, done_n, done_k;
        bit aborted;
        exp_q.delete();
        exp_res = sar_model(v);
        samp_n = 0; busy_n = 0; done_n = 0; done_k = -1; aborted = 0; acc_cyc = 0;
        @(negedge clk);
        vin = v; vref_sel = vs; start = 1'b1; abort = 1'b0;
        for (int k = 0; k <= LAT + 1; k++) begin
            @(posedge clk); #1;
            if (k == 0) acc_cyc = cyc;
            if (k == abort_k) begin
                check("abort_busy", busy, 0);
                check("abort_code", dac_code, 0);
                check("abort_sample", sample, 0);
                check("abort_done", done, 0);
                aborted = 1;
                break;
            end
            if (sample === 1'b1) samp_n++;
            if (busy === 1'b1) busy_n++;
            if (k < 2) check("sample_high", sample, 1);
            if (done === 1'b1) begin
                done_n++;
                done_k = k;
                check("result_at_done", result, exp_res);
            end
            if (k >= 2 && k <= 2 + 4 * (N - 1) && ((k - 2) % 4) == 0)
                check($sformatf("trial_b%0d", N - 1 - (k - 2) / 4), dac_code, exp_q.pop_front());
            if (k < LAT + 1) begin
                @(negedge clk);
                if (!hold) start = 1'b0;
                if (poke && (k == 5 || k == 20)) start = 1'b1;
                if (poke && k == 8) vref_sel = 4'hA;
                abort = (k + 1 == abort_k);
            end
        end
        if (aborted) begin
            @(negedge clk);
            abort = 1'b0;
            done_n = 0;
            repeat (LAT + 6) begin
                @(posedge clk); #1;
                if (done === 1'b1) done_n++;
            end
            check("abort_no_done", done_n, 0);
            check("abort_result_kept", result, prev_res);
            check("abort_vref_kept", vref_out, vs);
            check("abort_idle", busy, 0);
        end else begin
            check("done_count", done_n, 1);
            check("done_latency", done_k, LAT);
            check("sample_cycles", samp_n, 2);
            check("busy_cycles", busy_n, LAT + 1);
            check("vref_out", vref_out, vs);
            check("idle_after_done", busy, 0);
            check("code_held", dac_code, exp_res);
            check("result", result, exp_res);
            check("trials_used", exp_q.size(), 0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int acc, prev_acc;
        logic [N-1:0] rv;
        rst = 1'b1; start = 1'b0; abort = 1'b0; vref_sel = '0; vin = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_code", dac_code, 0);
        check("rst_vref", vref_out, 0);
        check("rst_sample", sample, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_result", result, 0);
        check("rst_state", state_dbg, IDLE_ST);
        @(negedge clk);
        rst = 1'b0;

        convert(8'hA5, 4'h3, -1, 0, 0, 8'h00, acc);
        convert(8'h00, 4'h1, -1, 0, 0, 8'hA5, acc);
        convert(8'hFF, 4'hF, -1, 0, 0, 8'h00, acc);

        // completed conversion, then one aborted at the 10th edge
        convert(8'h3C, 4'h7, -1, 0, 0, 8'hFF, acc);
        convert(8'h77, 4'h2, 10, 0, 0, 8'h3C, acc);

        // start re-pulsed and vref_sel changed while busy
        convert(8'($urandom_range(0, 255)), 4'h5, -1, 0, 1, 8'h3C, acc);

        // start held high: back-to-back conversions
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            convert(8'h5A, 4'h6, -1, 1, 0, 8'h00, acc);
            if (i > 0) check("accept_gap", acc - prev_acc, GAP);
            prev_acc = acc;
        end
        start = 1'b0;

        repeat (6) begin
            rv = 8'($urandom_range(0, 255));
            convert(rv, 4'($urandom_range(0, 15)), -1, 0, 0, 8'h00, acc);
        end

        // reset during SETTLE of bit 3 (vin=0x44: bits 7..4 give 0x40, trial 0x48)
        @(negedge clk);
        vin = 8'h44; vref_sel = 4'h9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check("pre_rst_trial", dac_code, 8'h48);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_code", dac_code, 0);
        check("midrst_vref", vref_out, 0);
        check("midrst_sample", sample, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_result", result, 0);
        check("midrst_state", state_dbg, IDLE_ST);
        @(negedge clk);
        rst = 1'b0; start = 1'b1; abort = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("start_abort_busy", busy, 0);
        check("start_abort_sample", sample, 0);
        check("start_abort_state", state_dbg, IDLE_ST);
        @(negedge clk);
        start = 1'b0; abort = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
